// File: rtl/boot_load_cpu.sv
// -----------------------------------------------------------------------------
// boot_load_cpu
//
// Accumulator CPU core. After reset it copies BOOT_LEN words from an external
// combinational-read ROM into an external RAM. It then fetches and executes
// 8-bit instructions from that RAM. Each instruction is opcode[7:4] and
// operand[3:0], and takes one FETCH cycle plus one EXEC cycle.
//
// Optional feature (macro CPU_CARRY_JUMP_EN):
//   - Adds a carry flag, written by ADD (carry-out) and SUB (borrow).
//   - Adds opcode B = JC and a 1-bit `carry` output.
//   - When the macro is undefined, opcode B is a NOP.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   rom_addr   ROM read address (boot count during BOOT, 0 otherwise)
//   rom_data   ROM read data, combinational from rom_addr
//   ram_addr   RAM address (boot count, pc, or operand)
//   ram_wdata  RAM write data
//   ram_rdata  RAM read data, combinational from ram_addr
//   ram_wr_en  RAM write strobe (BOOT and STA execute only)
//   boot_done  high once the copy has completed, sticky until reset
//   halted     high once HLT has executed, sticky until reset
//   acc        accumulator value
//   carry      carry flag (only with CPU_CARRY_JUMP_EN)
// -----------------------------------------------------------------------------
module boot_load_cpu #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 8,
  parameter int BOOT_LEN  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ADDR_SIZE-1:0] rom_addr,
  input  logic [WORD_SIZE-1:0] rom_data,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  input  logic [WORD_SIZE-1:0] ram_rdata,
  output logic                 ram_wr_en,
  output logic                 boot_done,
  output logic                 halted,
`ifdef CPU_CARRY_JUMP_EN
  output logic                 carry,
`endif
  output logic [WORD_SIZE-1:0] acc
);

  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_EXEC, ST_HALT} state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3,
    OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
    OP_LDI = 4'h8, OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB,
    OP_HLT = 4'hF
  } opcode_t;

  state_t               state, state_d;
  logic [3:0]           count, count_d;
  logic [3:0]           pc, pc_d;
  logic [WORD_SIZE-1:0] ir, ir_d;
  logic [WORD_SIZE-1:0] acc_d;
  logic                 zf, zf_d;
  logic                 upd_z;
  logic [3:0]           op;
  logic [3:0]           a;

  assign op = ir[WORD_SIZE-1 -: 4];
  assign a  = ir[3:0];

  // Status flags follow directly from the state, so they are sticky by
  // construction and clear as soon as reset forces BOOT.
  assign boot_done = (state != ST_BOOT);
  assign halted    = (state == ST_HALT);

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples its pre-edge inputs, whatever order the statements are written in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_BOOT;
      count <= '0;
      pc    <= '0;
      ir    <= '0;
      acc   <= '0;
      zf    <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      pc    <= pc_d;
      ir    <= ir_d;
      acc   <= acc_d;
      zf    <= zf_d;
    end
  end

`ifdef CPU_CARRY_JUMP_EN
  logic cf_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) carry <= 1'b0;
    else      carry <= cf_d;
  end
`endif

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    count_d   = count;
    pc_d      = pc;
    ir_d      = ir;
    acc_d     = acc;
    zf_d      = zf;
    upd_z     = 1'b0;
    rom_addr  = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wr_en = 1'b0;
`ifdef CPU_CARRY_JUMP_EN
    cf_d      = carry;
`endif

    unique case (state)
      ST_BOOT: begin
        rom_addr  = ADDR_SIZE'(count);
        ram_addr  = ADDR_SIZE'(count);
        ram_wdata = rom_data;
        ram_wr_en = 1'b1;
        count_d   = count + 4'd1;
        if (count == 4'(BOOT_LEN - 1)) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        ram_addr = ADDR_SIZE'(pc);
        ir_d     = ram_rdata;
        pc_d     = pc + 4'd1;  // 4-bit pc wraps 15 -> 0
        state_d  = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op)
          OP_LDA: begin
            ram_addr = ADDR_SIZE'(a);
            acc_d    = ram_rdata;
            upd_z    = 1'b1;
          end
          OP_STA: begin
            ram_addr  = ADDR_SIZE'(a);
            ram_wdata = acc;
            ram_wr_en = 1'b1;
          end
          OP_ADD: begin
            ram_addr = ADDR_SIZE'(a);
`ifdef CPU_CARRY_JUMP_EN
            {cf_d, acc_d} = {1'b0, acc} + {1'b0, ram_rdata};
`else
            acc_d = acc + ram_rdata;
`endif
            upd_z = 1'b1;
          end
          OP_SUB: begin
            ram_addr = ADDR_SIZE'(a);
            acc_d    = acc - ram_rdata;
`ifdef CPU_CARRY_JUMP_EN
            cf_d     = (acc < ram_rdata);
`endif
            upd_z    = 1'b1;
          end
          OP_AND: begin
            ram_addr = ADDR_SIZE'(a);
            acc_d    = acc & ram_rdata;
            upd_z    = 1'b1;
          end
          OP_OR: begin
            ram_addr = ADDR_SIZE'(a);
            acc_d    = acc | ram_rdata;
            upd_z    = 1'b1;
          end
          OP_XOR: begin
            ram_addr = ADDR_SIZE'(a);
            acc_d    = acc ^ ram_rdata;
            upd_z    = 1'b1;
          end
          OP_LDI: begin
            acc_d = {{(WORD_SIZE-4){1'b0}}, a};
            upd_z = 1'b1;
          end
          OP_JMP: pc_d = a;
          OP_JZ:  if (zf) pc_d = a;
`ifdef CPU_CARRY_JUMP_EN
          OP_JC:  if (carry) pc_d = a;
`endif
          OP_HLT: state_d = ST_HALT;
          default: ;  // NOP and unassigned opcodes
        endcase
      end

      ST_HALT: ;  // absorbing: no bus activity, registers frozen

      default: state_d = ST_BOOT;
    endcase

    if (upd_z) zf_d = (acc_d == '0);

    // Buses stay quiet while reset is held, even though the state is BOOT.
    if (!rst) begin
      rom_addr  = '0;
      ram_addr  = '0;
      ram_wdata = '0;
      ram_wr_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_boot_load_cpu.sv
// -----------------------------------------------------------------------------
// tb_boot_load_cpu
//
// Scoreboard bench for boot_load_cpu. It provides a ROM and a RAM around the
// DUT. Each test pushes the RAM writes it expects, and the accumulator value
// it expects at halt, into queues. A monitor on the falling clock edge pops
// and compares an entry whenever the DUT strobes ram_wr_en or raises halted.
// -----------------------------------------------------------------------------
module tb_boot_load_cpu;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rom_addr, ram_addr;
  logic [7:0] rom_data, ram_wdata, ram_rdata;
  logic       ram_wr_en, boot_done, halted;
  logic [7:0] acc;
`ifdef CPU_CARRY_JUMP_EN
  logic       carry;
`endif

  always #5 clk = ~clk;

  logic [7:0] rom [16];
  logic [7:0] ram [256];

  assign rom_data  = rom[rom_addr[3:0]];
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk) if (ram_wr_en) ram[ram_addr] <= ram_wdata;

  boot_load_cpu dut (
    .clk       (clk),
    .rst       (rst),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_wr_en (ram_wr_en),
    .boot_done (boot_done),
    .halted    (halted),
`ifdef CPU_CARRY_JUMP_EN
    .carry     (carry),
`endif
    .acc       (acc)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] hq[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents a write or a halt.
  logic halted_q = 1'b0;
  always @(negedge clk) begin
    wr_t e;
    if (ram_wr_en) begin
      if (wq.size() == 0) begin
        check("write_unexpected", {ram_addr, ram_wdata}, 32'hFFFF_FFFF);
      end else begin
        e = wq.pop_front();
        check("write_addr", ram_addr, e.addr);
        check("write_data", ram_wdata, e.data);
      end
    end
    if (halted && !halted_q) begin
      if (hq.size() == 0) check("halt_unexpected", acc, 32'hFFFF_FFFF);
      else                check("halt_acc", acc, hq.pop_front());
    end
    halted_q <= halted;
  end

  // Image bytes listed from address 0 (most significant) to 15.
  task automatic load_rom(input logic [127:0] img);
    for (int i = 0; i < 16; i++) rom[i] = img[8*(15-i) +: 8];
  endtask

  // Reset, check the reset outputs, then release and expect the 16-word copy.
  task automatic boot();
    int n;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_boot_done", boot_done, 0);
    check("rst_halted",    halted,    0);
    check("rst_acc",       acc,       0);
    check("rst_wr_en",     ram_wr_en, 0);
    check("rst_rom_addr",  rom_addr,  0);
    check("rst_ram_addr",  ram_addr,  0);
    check("rst_wdata",     ram_wdata, 0);
    wq.delete();
    hq.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) wq.push_back('{addr: 8'(i), data: rom[i]});
    rst = 1'b1;
    n = 0;
    while (!boot_done && n <= 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("boot_cycles", n, 16);
    check("boot_rom_addr_idle", rom_addr, 0);
  endtask

  task automatic run_to_halt(input int exp_cycles);
    int n = 0;
    while (!halted && n <= 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("halt_cycles", n, exp_cycles);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && (wq.size() + hq.size()) != 0; i++) begin
      @(negedge clk); #1;
    end
    check("sb_drained", wq.size() + hq.size(), 0);
  endtask

  initial begin
    // Boot copy: RAM[0..15] must mirror ROM afterwards.
    load_rom(128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF);
    boot();
    for (int i = 0; i < 16; i++) check("boot_ram_copy", ram[i], 8'hA0 + 8'(i));

    // Reset at boot count 7: seven writes seen, then the copy restarts at 0.
    @(posedge clk); #1;
    rst = 1'b0;
    wq.delete();
    hq.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) wq.push_back('{addr: 8'(i), data: rom[i]});
    rst = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midboot_pending", wq.size(), 0);
    check("midboot_boot_done", boot_done, 0);
    check("midboot_wr_en", ram_wr_en, 0);
    boot();

    // Arithmetic: LDI 5, ADD 8, STA 9, HLT with RAM[8]=3.
    load_rom(128'h853829F0_00000000_03000000_00000000);
    boot();
    wq.push_back('{addr: 8'd9, data: 8'h08});
    hq.push_back(8'h08);
    run_to_halt(8);
    repeat (3) @(posedge clk);
    #1;
    check("arith_ram9", ram[9], 8'h08);
    check("arith_acc_frozen", acc, 8'h08);
    check("arith_halt_sticky", halted, 1);
    check("arith_halt_wr_en", ram_wr_en, 0);
    drain(10);

    // Zero flag and taken branch.
    load_rom(128'h80A587F0_0082F000_00000000_00000000);
    boot();
    hq.push_back(8'h02);
    run_to_halt(8);
    drain(10);

    // XOR to 0x0F, then 0x00 - 0x01 = 0xFF with zero flag clear (JZ not taken).
    load_rom(128'h18792A80_4BA7F083_F0FF0001_00000000);
    boot();
    wq.push_back('{addr: 8'd10, data: 8'h0F});
    hq.push_back(8'hFF);
    run_to_halt(14);
    check("logic_ram10", ram[10], 8'h0F);
    drain(10);

    // 0xFF + 0x01 -> 0x00; opcode B is JC with the macro, a NOP without it.
    load_rom(128'h1839B581_F089F000_FF010000_00000000);
    boot();
`ifdef CPU_CARRY_JUMP_EN
    hq.push_back(8'h09);
`else
    hq.push_back(8'h01);
`endif
    run_to_halt(10);
`ifdef CPU_CARRY_JUMP_EN
    check("carry_set", carry, 1);
`endif
    drain(10);

    // Reset while halted clears the status and accumulator immediately.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_halted_clear", halted, 0);
    check("rst_acc_clear", acc, 0);
    check("rst_boot_done_clear", boot_done, 0);

    // No HLT: ADD 15 / STA 14 run again after the pc wraps from 15 to 0.
    load_rom(128'h3F2E0000_00000000_00000000_0000000C);
    boot();
    wq.push_back('{addr: 8'd14, data: 8'h0C});
    wq.push_back('{addr: 8'd14, data: 8'h18});
    drain(100);
    rst = 1'b0;
    #20;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/boot_load_cpu.md
Name: boot_load_cpu

Overview:
- Accumulator CPU core that, after reset, copies a fixed-length program image from ROM into RAM, then fetches and executes instructions from RAM.
- Sits between a combinational-read ROM and a RAM with synchronous write and combinational read. Both memories are external to this block.
- Used as the compute core of the basic CPU system. It also exposes boot and halt status for benches.

Parameters:
- WORD_SIZE, 8, data and instruction width. Encoding is fixed for 8: opcode[7:4], operand[3:0].
- ADDR_SIZE, 8, width of rom_addr and ram_addr. The upper ADDR_SIZE-4 bits are always 0 during execution.
- BOOT_LEN, 16, number of words copied from ROM[0..BOOT_LEN-1] to RAM[0..BOOT_LEN-1]. Legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- rom_addr  output  ADDR_SIZE  ROM read address.
- rom_data  input  WORD_SIZE  ROM read data, combinational from rom_addr.
- ram_addr  output  ADDR_SIZE  RAM address.
- ram_wdata  output  WORD_SIZE  RAM write data.
- ram_rdata  input  WORD_SIZE  RAM read data, combinational from ram_addr.
- ram_wr_en  output  1  RAM write strobe; RAM writes on the clk edge while this is high.
- boot_done  output  1  high once the copy completes; sticky until reset.
- halted  output  1  high after HLT executes; sticky until reset.
- acc  output  WORD_SIZE  accumulator value, for observability.

Behaviour:
- Reset (rst=0, async): state=BOOT, boot count=0, pc=0, ir=0, acc=0, zero flag=0. Outputs: boot_done=0, halted=0, ram_wr_en=0, all buses 0.
- BOOT state:
  - Each cycle at count i: rom_addr=i, ram_addr=i, ram_wdata=rom_data, ram_wr_en=1.
  - Count increments each cycle.
  - After the write of i=BOOT_LEN-1: boot_done=1, go to FETCH.
  - The copy takes exactly BOOT_LEN cycles after reset release.
- rom_addr: 0 outside BOOT.
- FETCH state: ram_addr=pc, ir<=ram_rdata, pc<=pc+1 mod 16 (15 wraps to 0), then EXEC.
- EXEC state: operand a=ir[3:0]; ram_addr=a for memory operations. Return to FETCH unless HLT.
- Every instruction takes exactly 2 cycles.
- Opcodes:
  - 0 NOP.
  - 1 LDA: acc=RAM[a].
  - 2 STA: ram_wdata=acc, ram_wr_en=1, write to a.
  - 3 ADD: acc=acc+RAM[a], mod 2^WORD_SIZE.
  - 4 SUB: acc=acc-RAM[a], mod 2^WORD_SIZE.
  - 5 AND, 6 OR, 7 XOR: bitwise with RAM[a].
  - 8 LDI: acc=zero-extended a.
  - 9 JMP: pc=a.
  - A JZ: pc=a if zero flag=1, else no change.
  - F HLT: enter HALT, halted=1.
  - All others: NOP.
- Zero flag: updated to (new acc==0) by opcodes 1, 3–8 only.
- ram_wr_en: high only in BOOT and during STA's EXEC cycle.
- HALT state: absorbing. No bus activity (ram_wr_en=0), acc and pc frozen until reset.
- Reset mid-boot or mid-execution returns immediately to BOOT with all reset values, and the copy restarts at 0.

Optional Feature:
- Macro CPU_CARRY_JUMP_EN.
- When defined:
  - A carry flag exists, reset to 0.
  - ADD sets carry to the carry-out of bit WORD_SIZE-1.
  - SUB sets carry to 1 on borrow (acc < RAM[a]).
  - Other opcodes leave carry unchanged.
  - Opcode B = JC: pc=a if carry=1, else no change.
  - An extra output port carry (1 bit) exposes the flag.
- When not defined: no carry flag, no carry port, opcode B is a NOP.

Test Plan:
- Boot copy: ROM[i]=0xA0+i, BOOT_LEN=16; release rst -> ram_wr_en=1 with ram_addr=ram_wdata index sequence for 16 cycles, boot_done rises after the 16th write, RAM[0..15] matches ROM.
- Arithmetic: ROM = 0x85 (LDI 5), 0x38 (ADD 8), 0x29 (STA 9), 0xF0 (HLT), ROM[8]=0x03 -> RAM[9]=0x08, acc=0x08, halted=1 exactly 8 cycles after boot_done.
- Zero and branch: LDI 0, JZ 5, LDI 7, HLT at addresses 0–3; LDI 2, HLT at 5–6 -> acc=0x02, halted=1.
- Wrap and logic: acc=0xF0, XOR with 0xFF -> acc=0x0F. SUB of 0x01 from 0x00 -> acc=0xFF, zero flag=0. A program with no HLT runs through address 15 and pc wraps to 0.
- Reset mid-operation: pull rst low at boot count 7, release -> boot restarts at address 0, boot_done=0 until 16 further writes. Reset while halted -> halted=0 and acc=0 immediately.
- CPU_CARRY_JUMP_EN: acc=0xFF, ADD of 0x01 -> acc=0x00, carry=1, JC taken. Without the macro, opcode 0xB_ acts as NOP.
